// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, depth and types for the SPI TX FIFO.
package spi_pkg;
   localparam int SPI_DW = 12;
   localparam int SPI_TX_DEPTH = 8;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} tx_state_e;
   typedef struct packed {
      logic cmd;
      logic [SPI_DW-1:0] data;
   } tx_entry_t;
endpackage

// File: rtl/spi_tx_fifo_mem.sv
// spi_tx_fifo_mem: DEPTH x (DW+1) register array, synchronous write, asynchronous read.
module spi_tx_fifo_mem
   import spi_pkg::*;
#(
   parameter int DW = SPI_DW,
   parameter int DEPTH = SPI_TX_DEPTH
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [DW:0]              wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [DW:0]              rdata_o
);
   logic [DW:0] mem_q [DEPTH];
   always_ff @(posedge clk)
      if (we_i) mem_q[waddr_i] <= wdata_i;
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: buffers {cmd, data} words from wishbone_if and replays them to spi_if via wr/ack.
// Optional SPI_TX_FIFO_STATUS_EN adds level and sticky ovf outputs.
module spi_tx_fifo
   import spi_pkg::*;
#(
   parameter int DW = SPI_DW,
   parameter int DEPTH = SPI_TX_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DW-1:0]          in_data,
   input  logic                   in_cmd,
   input  logic                   in_wr,
   output logic                   in_full,
   input  logic                   flush,
   output logic [DW-1:0]          out_data,
   output logic                   out_cmd,
   output logic                   out_wr,
   input  logic                   out_ack,
   output logic                   empty,
   output logic                   busy
`ifdef SPI_TX_FIFO_STATUS_EN
   ,
   output logic [$clog2(DEPTH):0] level,
   output logic                   ovf
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [AW:0] FULL_GAP = PW'(DEPTH);
   tx_state_e state_q, state_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic out_cmd_q, out_cmd_d, in_full_q, in_full_d, empty_q, empty_d;
   logic push, pop, load;
   logic [DW:0] head;
   spi_tx_fifo_mem #(.DW(DW), .DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i ({in_cmd, in_data}),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (head)
   );
   assign push = in_wr & ~in_full_q & ~flush;
   assign pop = (state_q == WAIT_ACK) & out_ack;
   assign load = (state_q == IDLE) & ~empty_q & ~flush;
   always_comb begin
      state_d = (state_q == IDLE) ? (load ? ISSUE : IDLE) :
                (state_q == ISSUE) ? WAIT_ACK : (out_ack ? IDLE : WAIT_ACK);
      // A flush while busy keeps the in-flight head so its ack still pops it.
      wr_ptr_d = flush ? rd_ptr_q + PW'(busy) : wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      in_full_d = (wr_ptr_d - rd_ptr_d) == FULL_GAP;
      empty_d = wr_ptr_d == rd_ptr_d;
      out_data_d = load ? head[DW-1:0] : out_data_q;
      out_cmd_d = load ? head[DW] : out_cmd_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         out_data_q <= '0;
         out_cmd_q <= 1'b0;
         in_full_q <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         state_q <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         out_data_q <= out_data_d;
         out_cmd_q <= out_cmd_d;
         in_full_q <= in_full_d;
         empty_q <= empty_d;
      end
   assign out_wr = state_q == ISSUE;
   assign busy = state_q != IDLE;
   assign out_data = out_data_q;
   assign out_cmd = out_cmd_q;
   assign in_full = in_full_q;
   assign empty = empty_q;
`ifdef SPI_TX_FIFO_STATUS_EN
   logic ovf_q, ovf_d;
   assign ovf_d = flush ? 1'b0 : ovf_q | (in_wr & in_full_q);
   always_ff @(posedge clk or posedge rst)
      if (rst) ovf_q <= 1'b0;
      else ovf_q <= ovf_d;
   assign level = wr_ptr_q - rd_ptr_q;
   assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_spi_tx_fifo.sv
// tb_spi_tx_fifo: directed self-checking bench for spi_tx_fifo (checks level/ovf when SPI_TX_FIFO_STATUS_EN is defined).
module tb_spi_tx_fifo;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [11:0] in_data = '0;
   logic in_cmd = 1'b0, in_wr = 1'b0, flush = 1'b0, out_ack = 1'b0;
   logic in_full, out_cmd, out_wr, empty, busy;
   logic [11:0] out_data;
`ifdef SPI_TX_FIFO_STATUS_EN
   logic [3:0] level;
   logic ovf;
`endif
   int checks = 0, errors = 0, n_issued = 0, base = 0;

   spi_tx_fifo dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_cmd   (in_cmd),
      .in_wr    (in_wr),
      .in_full  (in_full),
      .flush    (flush),
      .out_data (out_data),
      .out_cmd  (out_cmd),
      .out_wr   (out_wr),
      .out_ack  (out_ack),
      .empty    (empty),
      .busy     (busy)
`ifdef SPI_TX_FIFO_STATUS_EN
      ,
      .level    (level),
      .ovf      (ovf)
`endif
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (out_wr === 1'b1) n_issued++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [11:0] d, input logic c);
      in_data = d;
      in_cmd = c;
      in_wr = 1'b1;
      step();
      in_wr = 1'b0;
   endtask

   task automatic ack();
      out_ack = 1'b1;
      step();
      out_ack = 1'b0;
   endtask

   task automatic wait_ack_state(input string tag);
      int n = 0;
      while (!(busy === 1'b1 && out_wr === 1'b0) && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_reach_wait"}, 32'(n < 20), 32'd1);
   endtask

   task automatic drain_one(input logic [11:0] d, input string tag);
      wait_ack_state(tag);
      chk(tag, 32'(out_data), 32'(d));
      ack();
   endtask

   initial begin
      #1 rst = 1'b1;
      #2;
      chk("rst_out_wr", 32'(out_wr), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_cmd", 32'(out_cmd), 0);
      chk("rst_in_full", 32'(in_full), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_busy", 32'(busy), 0);
      step();
      step();
      rst = 1'b0;
      step();

      base = n_issued;
      push(12'h5A3, 1'b1);
      chk("sw_empty_after_push", 32'(empty), 0);
      chk("sw_no_wr_yet", 32'(out_wr), 0);
      step();
      chk("sw_out_wr", 32'(out_wr), 1);
      chk("sw_out_data", 32'(out_data), 32'h5A3);
      chk("sw_out_cmd", 32'(out_cmd), 1);
      step();
      chk("sw_wr_one_cycle", 32'(out_wr), 0);
      chk("sw_busy_wait", 32'(busy), 1);
      repeat (3) step();
      chk("sw_hold_data", 32'(out_data), 32'h5A3);
      ack();
      chk("sw_empty_after_ack", 32'(empty), 1);
      chk("sw_idle_after_ack", 32'(busy), 0);
      chk("sw_issue_count", 32'(n_issued - base), 1);

      base = n_issued;
      for (int i = 1; i <= 9; i++) begin
         push(12'(i), 1'b0);
         if (i == 7) chk("fill_not_full_7", 32'(in_full), 0);
         if (i == 8) chk("fill_full_8", 32'(in_full), 1);
      end
      chk("fill_full_after_9", 32'(in_full), 1);
`ifdef SPI_TX_FIFO_STATUS_EN
      chk("fill_level", 32'(level), 8);
      chk("fill_ovf", 32'(ovf), 1);
`endif
      drain_one(12'h001, "fill_d1");
      chk("fill_not_full_after_pop", 32'(in_full), 0);
      for (int i = 2; i <= 8; i++) drain_one(12'(i), "fill_d");
      step();
      chk("fill_empty", 32'(empty), 1);
      chk("fill_issue_count", 32'(n_issued - base), 8);
`ifdef SPI_TX_FIFO_STATUS_EN
      chk("fill_ovf_sticky", 32'(ovf), 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fill_ovf_cleared", 32'(ovf), 0);
`endif

      base = n_issued;
      for (int s = 0; s < 20; s += 3) begin
         int k;
         k = (20 - s < 3) ? 20 - s : 3;
         for (int j = 0; j < k; j++) push(12'h300 + 12'(s + j), 1'(j));
         for (int j = 0; j < k; j++) drain_one(12'h300 + 12'(s + j), "wrap_d");
         step();
         chk("wrap_empty", 32'(empty), 1);
      end
      chk("wrap_issue_count", 32'(n_issued - base), 20);

      base = n_issued;
      for (int i = 0; i < 4; i++) push(12'h100 + 12'(i), 1'b0);
      wait_ack_state("flush");
      chk("flush_head", 32'(out_data), 32'h100);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_busy", 32'(busy), 1);
      chk("flush_inflight_stored", 32'(empty), 0);
      ack();
      chk("flush_empty", 32'(empty), 1);
      repeat (8) step();
      chk("flush_no_more_wr", 32'(n_issued - base), 1);
      chk("flush_idle", 32'(busy), 0);
      in_data = 12'h3FF;
      in_wr = 1'b1;
      flush = 1'b1;
      step();
      in_wr = 1'b0;
      flush = 1'b0;
      chk("flush_beats_push", 32'(empty), 1);
      repeat (4) step();
      chk("flush_push_not_issued", 32'(n_issued - base), 1);

      push(12'h0AB, 1'b1);
      wait_ack_state("arst");
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_out_wr", 32'(out_wr), 0);
      chk("arst_out_data", 32'(out_data), 0);
      chk("arst_out_cmd", 32'(out_cmd), 0);
      chk("arst_empty", 32'(empty), 1);
      chk("arst_in_full", 32'(in_full), 0);
      step();
      rst = 1'b0;
      base = n_issued;
      ack();
      repeat (5) step();
      chk("arst_late_ack_no_wr", 32'(n_issued - base), 0);
      chk("arst_late_ack_empty", 32'(empty), 1);
      push(12'h0CD, 1'b1);
      drain_one(12'h0CD, "arst_next");
      chk("arst_next_cmd", 32'(out_cmd), 1);
      step();
      chk("arst_next_empty", 32'(empty), 1);

      base = n_issued;
      in_data = 12'h201;
      in_cmd = 1'b0;
      in_wr = 1'b1;
      out_ack = 1'b1;
      step();
      in_data = 12'h202;
      step();
      in_wr = 1'b0;
      chk("spur_issue_first", 32'(out_wr), 1);
      chk("spur_first_data", 32'(out_data), 32'h201);
      step();
      out_ack = 1'b0;
      repeat (3) step();
      chk("spur_still_waiting", 32'(busy), 1);
      chk("spur_not_empty", 32'(empty), 0);
      chk("spur_hold_data", 32'(out_data), 32'h201);
      ack();
      drain_one(12'h202, "spur_second");
      step();
      chk("spur_empty", 32'(empty), 1);
      chk("spur_issue_count", 32'(n_issued - base), 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
